// File: rtl/tlul_pkg.sv
// TL-UL request/response bundles and opcode encodings shared by hosts,
// crossbar and device endpoints.
package tlul_pkg;

  // A-channel opcodes
  localparam logic [2:0] PutFullData    = 3'h0;
  localparam logic [2:0] PutPartialData = 3'h1;
  localparam logic [2:0] Get            = 3'h4;

  // D-channel opcodes
  localparam logic [2:0] AccessAck      = 3'h0;
  localparam logic [2:0] AccessAckData  = 3'h1;

  typedef struct packed {
    logic        a_valid;
    logic [2:0]  a_opcode;
    logic [2:0]  a_param;
    logic [1:0]  a_size;
    logic [7:0]  a_source;
    logic [31:0] a_address;
    logic [3:0]  a_mask;
    logic [31:0] a_data;
    logic [3:0]  a_user;
    logic        d_ready;
  } tl_h2d_t;

  typedef struct packed {
    logic        d_valid;
    logic [2:0]  d_opcode;
    logic [2:0]  d_param;
    logic [1:0]  d_size;
    logic [7:0]  d_source;
    logic        d_sink;
    logic [31:0] d_data;
    logic [3:0]  d_user;
    logic        d_error;
    logic        a_ready;
  } tl_d2h_t;

endpackage

// File: rtl/tlul_mem_responder_if.sv
// TL-UL link bundle: host-to-device request and device-to-host response.
interface tlul_mem_responder_if;
  import tlul_pkg::*;

  tl_h2d_t h2d;
  tl_d2h_t d2h;

  modport master (output h2d, input  d2h);
  modport slave  (input  h2d, output d2h);
endinterface

// File: rtl/tlul_mem_responder.sv
// TL-UL memory device: serves Get/PutFullData/PutPartialData from a
// word-addressed memory and returns responses in order through a small FIFO.
// Build option: define TLUL_MEM_RESPONDER_CLR_EN to clear the memory on rst_ni;
// otherwise the memory has no reset and keeps its contents across rst_ni.
module tlul_mem_responder
  import tlul_pkg::*;
#(
  parameter int unsigned MemWords     = 256,
  parameter int unsigned RspFifoDepth = 2
) (
  input  logic    clk_i,
  input  logic    rst_ni,
  input  tl_h2d_t tl_i,
  output tl_d2h_t tl_o
);

  localparam int unsigned AddrW = $clog2(MemWords);
  localparam int unsigned PtrW  = (RspFifoDepth > 1) ? $clog2(RspFifoDepth) : 1;
  localparam int unsigned CntW  = $clog2(RspFifoDepth + 1);
  localparam logic [31:0]     MemBytes = 32'(MemWords * 4);
  localparam logic [PtrW-1:0] LastPtr  = PtrW'(RspFifoDepth - 1);
  localparam logic [CntW-1:0] DepthCnt = CntW'(RspFifoDepth);

  typedef struct packed {
    logic [2:0]  opcode;
    logic [1:0]  size;
    logic [7:0]  source;
    logic [31:0] data;
    logic        error;
  } rsp_t;

  logic [31:0]     mem_q [MemWords];
  rsp_t            fifo_q [RspFifoDepth];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic            rst_done_q;

  logic            a_ready, accept, pop, d_valid;
  logic            req_err, op_ok, is_put, do_write;
  logic [3:0]      byte_en;
  logic [AddrW-1:0] word_idx;
  rsp_t            rsp, head;

  // Fields a memory endpoint has no use for.
  logic unused_tl;
  assign unused_tl = ^{tl_i.a_param, tl_i.a_user};

  assign a_ready  = rst_done_q & (count_q < DepthCnt);
  assign accept   = tl_i.a_valid & a_ready;
  assign d_valid  = (count_q != '0);
  assign pop      = d_valid & tl_i.d_ready;
  assign word_idx = tl_i.a_address[AddrW+1:2];
  assign head     = fifo_q[rd_ptr_q];

  // Request decode: legality, write enables and the response to enqueue.
  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    op_ok   = 1'b0;
    is_put  = 1'b0;
    byte_en = 4'h0;
    rsp     = '0;
    if (tl_i.a_opcode == Get) op_ok = 1'b1;
    if (tl_i.a_opcode == PutFullData || tl_i.a_opcode == PutPartialData) begin
      op_ok  = 1'b1;
      is_put = 1'b1;
    end
    req_err = (tl_i.a_address >= MemBytes) | (tl_i.a_address[1:0] != 2'b00) |
              (tl_i.a_size > 2'd2) | ~op_ok |
              ((tl_i.a_opcode == PutFullData) & (tl_i.a_mask != 4'hF));
    if (tl_i.a_opcode == PutFullData) byte_en = 4'hF;
    else if (tl_i.a_opcode == PutPartialData) byte_en = tl_i.a_mask;
    do_write = accept & is_put & ~req_err;

    rsp.opcode = (tl_i.a_opcode == Get) ? AccessAckData : AccessAck;
    rsp.size   = tl_i.a_size;
    rsp.source = tl_i.a_source;
    rsp.error  = req_err;
    if (tl_i.a_opcode == Get && !req_err) rsp.data = mem_q[word_idx];
  end

`ifdef TLUL_MEM_RESPONDER_CLR_EN
  // Memory write with byte lanes; reset clears every word.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < MemWords; i++) mem_q[i] <= '0;
    end else if (do_write) begin
      for (int b = 0; b < 4; b++) begin
        if (byte_en[b]) mem_q[word_idx][8*b +: 8] <= tl_i.a_data[8*b +: 8];
      end
    end
  end
`else
  // Memory write with byte lanes; contents survive reset.
  // NOTE: storage arrays carry no reset so they map onto plain RAM/flops;
  // only control state is reset.
  always_ff @(posedge clk_i) begin
    if (do_write) begin
      for (int b = 0; b < 4; b++) begin
        if (byte_en[b]) mem_q[word_idx][8*b +: 8] <= tl_i.a_data[8*b +: 8];
      end
    end
  end
`endif

  // Response FIFO storage; entries are only observed while count is nonzero.
  always_ff @(posedge clk_i) begin
    if (accept) fifo_q[wr_ptr_q] <= rsp;
  end

  // FIFO pointer and occupancy next-state, wrapping modulo the depth.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (accept) wr_ptr_d = (wr_ptr_q == LastPtr) ? '0 : wr_ptr_q + 1'b1;
    if (pop)    rd_ptr_d = (rd_ptr_q == LastPtr) ? '0 : rd_ptr_q + 1'b1;
    if (accept && !pop)      count_d = count_q + 1'b1;
    else if (pop && !accept) count_d = count_q - 1'b1;
  end

  // Control state registers.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // updates from pre-edge values regardless of statement order.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      rst_done_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      rst_done_q <= 1'b1;
    end
  end

  // D channel driven from the FIFO head; all fields read zero when idle.
  always_comb begin
    tl_o         = '0;
    tl_o.a_ready = a_ready;
    if (d_valid) begin
      tl_o.d_valid  = 1'b1;
      tl_o.d_opcode = head.opcode;
      tl_o.d_size   = head.size;
      tl_o.d_source = head.source;
      tl_o.d_data   = head.data;
      tl_o.d_error  = head.error;
    end
  end

endmodule

// File: tb/tb_tlul_mem_responder.sv
// Scoreboard bench for tlul_mem_responder: directed scenarios followed by
// randomized traffic, checked against a byte-level memory model.
module tb_tlul_mem_responder;
  import tlul_pkg::*;

  localparam int unsigned MemWords = 256;
  localparam int unsigned Depth    = 2;

  logic clk_i  = 1'b0;
  logic rst_ni = 1'b0;
  always #5 clk_i = ~clk_i;

  tlul_mem_responder_if bus ();

  tlul_mem_responder #(.MemWords(MemWords), .RspFifoDepth(Depth)) dut (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .tl_i   (bus.h2d),
    .tl_o   (bus.d2h)
  );

  typedef struct {
    logic [2:0]  opcode;
    logic [1:0]  size;
    logic [7:0]  source;
    logic [31:0] data;
    logic [31:0] kmask;
    logic        error;
  } exp_t;

  exp_t       exp_q [$];
  exp_t       mon_e;
  logic [7:0] ref_mem   [MemWords*4];
  bit         ref_known [MemWords*4];
  int         n_checks = 0;
  int         n_pass   = 0;
  bit         rnd_ready = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  function automatic void model_reset_mem();
`ifdef TLUL_MEM_RESPONDER_CLR_EN
    for (int i = 0; i < MemWords*4; i++) begin
      ref_mem[i]   = 8'h00;
      ref_known[i] = 1'b1;
    end
`endif
  endfunction

  // Reference behaviour of one accepted request.
  function automatic void model_accept(input logic [2:0] op, input logic [31:0] addr,
                                       input logic [1:0] size, input logic [3:0] mask,
                                       input logic [31:0] data, input logic [7:0] src);
    exp_t e;
    bit   err;
    int   base;
    err = (addr >= 32'(MemWords*4)) || (addr[1:0] != 2'b00) || (size > 2'd2) ||
          !(op == Get || op == PutFullData || op == PutPartialData) ||
          (op == PutFullData && mask != 4'hF);
    e.opcode = (op == Get) ? AccessAckData : AccessAck;
    e.size   = size;
    e.source = src;
    e.error  = err;
    e.data   = '0;
    e.kmask  = '1;
    if (!err) begin
      base = int'(addr);
      for (int b = 0; b < 4; b++) begin
        if (op == Get) begin
          e.data[8*b +: 8]  = ref_mem[base+b];
          e.kmask[8*b +: 8] = ref_known[base+b] ? 8'hFF : 8'h00;
        end else if (op == PutFullData || mask[b]) begin
          ref_mem[base+b]   = data[8*b +: 8];
          ref_known[base+b] = 1'b1;
        end
      end
    end
    exp_q.push_back(e);
  endfunction

  // Monitor: whenever the model owes a response the DUT must present it.
  always @(negedge clk_i) begin
    if (rst_ni) begin
      check("d_valid", bus.d2h.d_valid, exp_q.size() != 0);
      if (bus.d2h.d_valid && exp_q.size() != 0) begin
        mon_e = exp_q[0];
        check("d_opcode", bus.d2h.d_opcode, mon_e.opcode);
        check("d_size",   bus.d2h.d_size,   mon_e.size);
        check("d_source", bus.d2h.d_source, mon_e.source);
        check("d_error",  bus.d2h.d_error,  mon_e.error);
        check("d_data",   bus.d2h.d_data & mon_e.kmask, mon_e.data & mon_e.kmask);
        check("d_zero_fields", {bus.d2h.d_param, bus.d2h.d_sink, bus.d2h.d_user}, 0);
        if (bus.h2d.d_ready) void'(exp_q.pop_front());
      end
    end
  end

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send(input logic [2:0] op, input logic [31:0] addr, input logic [1:0] size,
                      input logic [3:0] mask, input logic [31:0] data, input logic [7:0] src);
    if (rnd_ready) bus.h2d.d_ready = ($urandom_range(0, 3) != 0);
    bus.h2d.a_valid   = 1'b1;
    bus.h2d.a_opcode  = op;
    bus.h2d.a_address = addr;
    bus.h2d.a_size    = size;
    bus.h2d.a_mask    = mask;
    bus.h2d.a_data    = data;
    bus.h2d.a_source  = src;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk_i);
      if (bus.d2h.a_ready) begin
        @(posedge clk_i);
        model_accept(op, addr, size, mask, data, src);
        #1 bus.h2d.a_valid = 1'b0;
        return;
      end
      @(posedge clk_i);
      #1 if (rnd_ready) bus.h2d.d_ready = ($urandom_range(0, 3) != 0);
    end
    check("a_ready_timeout", bus.d2h.a_ready, 1);
    bus.h2d.a_valid = 1'b0;
  endtask

  task automatic drain();
    bus.h2d.d_ready = 1'b1;
    for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(posedge clk_i);
    @(posedge clk_i);
    #1 check("drain_empty", exp_q.size(), 0);
  endtask

  task automatic do_reset();
    rst_ni = 1'b0;
    bus.h2d.a_valid = 1'b0;
    #1;
    exp_q.delete();
    model_reset_mem();
    check("rst_d_valid", bus.d2h.d_valid, 0);
    check("rst_tl_o_zero", bus.d2h === '0, 1);
    repeat (2) @(posedge clk_i);
    #1 rst_ni = 1'b1;
    @(negedge clk_i);
    check("a_ready_before_done", bus.d2h.a_ready, 0);
    @(posedge clk_i);
    #1 check("a_ready_after_release", bus.d2h.a_ready, 1);
    check("d_valid_after_release", bus.d2h.d_valid, 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [2:0]  op;
    logic [31:0] addr;
    logic [1:0]  size;
    logic [3:0]  mask;
    int          sel;

    bus.h2d = '0;
    do_reset();

    // First read after reset, latency of a response into an empty FIFO.
    bus.h2d.d_ready = 1'b1;
    send(Get, 32'h10, 2'd2, 4'hF, 32'h0, 8'd5);
    check("first_rsp_latency", bus.d2h.d_valid, 1);
    drain();

    // Full write then back-to-back read; byte-lane partial write.
    send(PutFullData,    32'h20, 2'd2, 4'hF,    32'hDEADBEEF, 8'd1);
    send(Get,            32'h20, 2'd2, 4'hF,    32'h0,        8'd2);
    send(PutPartialData, 32'h20, 2'd2, 4'b0101, 32'h11223344, 8'd3);
    send(Get,            32'h20, 2'd2, 4'hF,    32'h0,        8'd4);
    send(PutPartialData, 32'h20, 2'd2, 4'b0000, 32'hFFFFFFFF, 8'd5);
    // Error cases leave memory unchanged.
    send(Get,            32'h400, 2'd2, 4'hF,   32'h0,        8'd6);
    send(Get,            32'h22,  2'd2, 4'hF,   32'h0,        8'd7);
    send(PutFullData,    32'h20,  2'd2, 4'h3,   32'hCAFEF00D, 8'd8);
    send(Get,            32'h20,  2'd3, 4'hF,   32'h0,        8'd9);
    send(3'h2,           32'h20,  2'd2, 4'hF,   32'h0,        8'd10);
    send(Get,            32'h20,  2'd2, 4'hF,   32'h0,        8'd11);
    drain();

    // Backpressure: FIFO fills, a_ready drops, reopens a cycle after a pop.
    bus.h2d.d_ready = 1'b0;
    send(Get, 32'h20, 2'd2, 4'hF, 32'h0, 8'd1);
    send(Get, 32'h24, 2'd2, 4'hF, 32'h0, 8'd2);
    bus.h2d.a_valid   = 1'b1;
    bus.h2d.a_opcode  = Get;
    bus.h2d.a_address = 32'h28;
    bus.h2d.a_source  = 8'd3;
    @(negedge clk_i);
    check("full_a_ready", bus.d2h.a_ready, 0);
    @(posedge clk_i);
    #1 bus.h2d.d_ready = 1'b1;
    @(negedge clk_i);
    check("full_a_ready_pop_cycle", bus.d2h.a_ready, 0);
    @(posedge clk_i);
    @(negedge clk_i);
    check("a_ready_after_pop", bus.d2h.a_ready, 1);
    @(posedge clk_i);
    model_accept(Get, 32'h28, 2'd2, 4'hF, 32'h0, 8'd3);
    #1 bus.h2d.a_valid = 1'b0;
    drain();

    // Reset with responses pending.
    bus.h2d.d_ready = 1'b0;
    send(PutFullData, 32'h30, 2'd2, 4'hF, 32'h12345678, 8'd7);
    send(Get,         32'h30, 2'd2, 4'hF, 32'h0,        8'd8);
    #3 rst_ni = 1'b0;
    #1 check("async_rst_d_valid", bus.d2h.d_valid, 0);
    do_reset();
    bus.h2d.d_ready = 1'b1;
    send(Get, 32'h30, 2'd2, 4'hF, 32'h0, 8'd9);
    send(Get, 32'h20, 2'd2, 4'hF, 32'h0, 8'd10);
    drain();

    // Randomized traffic with random d_ready backpressure.
    rnd_ready = 1'b1;
    for (int n = 0; n < 400; n++) begin
      sel = $urandom_range(0, 19);
      if (sel < 9)       op = Get;
      else if (sel < 14) op = PutFullData;
      else if (sel < 19) op = PutPartialData;
      else               op = 3'($urandom_range(2, 7));
      addr = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(MemWords-8, MemWords-1) * 4)
                                         : 32'($urandom_range(0, 15) * 4);
      sel = $urandom_range(0, 23);
      if (sel == 0) addr = addr | 32'($urandom_range(1, 3));
      if (sel == 1) addr = addr + 32'(MemWords*4);
      size = ($urandom_range(0, 9) == 0) ? 2'($urandom_range(0, 3)) : 2'd2;
      mask = 4'($urandom_range(0, 15));
      if (op == PutFullData && $urandom_range(0, 7) != 0) mask = 4'hF;
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk_i);
        #1;
      end
      send(op, addr, size, mask, $urandom, 8'($urandom));
    end
    rnd_ready = 1'b0;
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
